// File: rtl/lcd_message_writer.sv
// ---------------------------------------------------------------------------
// lcd_message_writer
//
// Drives an HD44780-compatible character LCD in 8-bit, write-only mode.
// After reset it waits for the panel to power up and sends the init
// sequence. Each accepted display request latches the status flags and the
// reaction time, converts the time to BCD and writes one 16-character
// line. LCDAck is then pulsed for one cycle.
//
// Parameters
//   E_CYCLES     clocks LCD_E is held high per byte
//   CMD_WAIT     idle clocks after each byte (except clear)
//   CLEAR_WAIT   idle clocks after the clear command 0x01
//   POWERUP_WAIT clocks to wait after reset before the first init byte
//
// Ports
//   Clk          system clock (1 kHz millisecond tick)
//   Rst          synchronous, active-high reset
//   LCDUpdate    level request, held high until acknowledged
//   Cheat/Slow/Wait  message-select flags, sampled at acceptance
//   ReactionTime reaction time in ms (0..1023), sampled at acceptance
//   LCDAck       one-cycle pulse once the line has been written
//   LCD_Data     LCD data bus
//   LCD_RS       0 = command, 1 = character
//   LCD_RW       always 0 (write only)
//   LCD_E        LCD enable strobe
//   Ready        high while idle and able to accept a request
// ---------------------------------------------------------------------------
module lcd_message_writer #(
    parameter int unsigned E_CYCLES     = 1,
    parameter int unsigned CMD_WAIT     = 1,
    parameter int unsigned CLEAR_WAIT   = 2,
    parameter int unsigned POWERUP_WAIT = 40
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       LCDUpdate,
    input  logic       Cheat,
    input  logic       Slow,
    input  logic       Wait,
    input  logic [9:0] ReactionTime,
    output logic       LCDAck,
    output logic [7:0] LCD_Data,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic       Ready
);

    typedef enum logic [2:0] {
        S_PowerUp,
        S_Init,
        S_Idle,
        S_Convert,
        S_Clear,
        S_Chars,
        S_Ack,
        S_Release
    } state_t;

    typedef enum logic [1:0] {
        MSG_TIME,
        MSG_WAIT,
        MSG_SLOW,
        MSG_CHEAT
    } msg_t;

    // Fixed 16-character line templates; character 0 is the leftmost byte.
    localparam logic [8*16-1:0] TXT_CHEAT = "CHEATER!        ";
    localparam logic [8*16-1:0] TXT_SLOW  = "TOO SLOW!       ";
    localparam logic [8*16-1:0] TXT_WAIT  = "GET READY...    ";
    localparam logic [8*16-1:0] TXT_TIME  = "TIME:      ms   ";

    state_t      state_q, state_d;
    msg_t        msg_q,   msg_d;
    logic [31:0] cnt_q,   cnt_d;    // power-up wait / cycle within current byte
    logic [4:0]  idx_q,   idx_d;    // init byte, conversion step or char index
    logic [25:0] dd_q,    dd_d;     // double-dabble register {bcd[15:0], bin[9:0]}

    logic [7:0]  cur_byte;
    logic        writing;
    logic [31:0] byte_len;
    logic        byte_last;
    logic [15:0] bcd_adj;
    logic [25:0] dd_step;

    // ------------------------------------------------------------------
    // Character generation
    // ------------------------------------------------------------------
    function automatic logic [7:0] txt_char(input logic [8*16-1:0] txt,
                                            input logic [3:0]      i);
        return txt[{4'd15 - i, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] msg_char(input msg_t        m,
                                            input logic [3:0]  i,
                                            input logic [15:0] bcd);
        logic [3:0] d_th, d_hu, d_te, d_on;
        logic [7:0] c;
        d_th = bcd[15:12];
        d_hu = bcd[11:8];
        d_te = bcd[7:4];
        d_on = bcd[3:0];
        case (m)
            MSG_CHEAT: c = txt_char(TXT_CHEAT, i);
            MSG_SLOW:  c = txt_char(TXT_SLOW, i);
            MSG_WAIT:  c = txt_char(TXT_WAIT, i);
            default: begin
                // Template already holds spaces at 6..9, so a blanked
                // leading zero simply keeps the template character.
                c = txt_char(TXT_TIME, i);
                case (i)
                    4'd6: if (d_th != 4'd0) c = {4'h3, d_th};
                    4'd7: if ((d_th | d_hu) != 4'd0) c = {4'h3, d_hu};
                    4'd8: if ((d_th | d_hu | d_te) != 4'd0) c = {4'h3, d_te};
                    4'd9: c = {4'h3, d_on};
                    default: ;
                endcase
            end
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Byte writer: the byte on the bus is a pure function of the state,
    // so RS/Data stay stable for the whole setup/strobe/wait sequence.
    // ------------------------------------------------------------------
    always_comb begin
        cur_byte = '0;
        writing  = 1'b0;
        case (state_q)
            S_Init: begin
                writing = 1'b1;
                case (idx_q[1:0])
                    2'd0:    cur_byte = 8'h38;
                    2'd1:    cur_byte = 8'h0C;
                    2'd2:    cur_byte = 8'h06;
                    default: cur_byte = 8'h01;
                endcase
            end
            S_Clear: begin
                writing  = 1'b1;
                cur_byte = 8'h01;
            end
            S_Chars: begin
                writing  = 1'b1;
                cur_byte = msg_char(msg_q, idx_q[3:0], dd_q[25:10]);
            end
            default: ;
        endcase
    end

    assign byte_len  = 32'd1 + E_CYCLES +
                       ((cur_byte == 8'h01) ? CLEAR_WAIT : CMD_WAIT);
    assign byte_last = (cnt_q == byte_len - 32'd1);

    // ------------------------------------------------------------------
    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    // ------------------------------------------------------------------
    always_comb begin
        bcd_adj = dd_q[25:10];
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
        dd_step = {bcd_adj, dd_q[9:0]} << 1;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dd_d    = dd_q;
        case (state_q)
            S_PowerUp: begin
                if (cnt_q + 32'd1 >= POWERUP_WAIT) begin
                    state_d = S_Init;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_Init: begin
                if (byte_last) begin
                    cnt_d = '0;
                    if (idx_q == 5'd3) begin
                        state_d = S_Idle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_Idle: begin
                if (LCDUpdate) begin
                    if (Cheat)      msg_d = MSG_CHEAT;
                    else if (Slow)  msg_d = MSG_SLOW;
                    else if (Wait)  msg_d = MSG_WAIT;
                    else            msg_d = MSG_TIME;
                    dd_d    = {16'h0000, ReactionTime};
                    idx_d   = '0;
                    state_d = S_Convert;
                end
            end
            S_Convert: begin
                dd_d = dd_step;
                if (idx_q == 5'd9) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_Clear;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_Clear: begin
                if (byte_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_Chars;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_Chars: begin
                if (byte_last) begin
                    cnt_d = '0;
                    if (idx_q == 5'd15) begin
                        idx_d   = '0;
                        state_d = S_Ack;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_Ack: begin
                state_d = S_Release;
            end
            S_Release: begin
                if (!LCDUpdate) state_d = S_Idle;
            end
            default: begin
                state_d = S_PowerUp;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_PowerUp;
            msg_q   <= MSG_TIME;
            cnt_q   <= '0;
            idx_q   <= '0;
            dd_q    <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dd_q    <= dd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decode to 0 in S_PowerUp, i.e. right after reset)
    // ------------------------------------------------------------------
    assign LCD_Data = cur_byte;
    assign LCD_RS   = (state_q == S_Chars);
    assign LCD_RW   = 1'b0;
    assign LCD_E    = writing && (cnt_q != '0) && (cnt_q <= E_CYCLES);
    assign Ready    = (state_q == S_Idle);
    assign LCDAck   = (state_q == S_Ack);

endmodule
